// File: rtl/hamming_pkg.sv
// Shared constants, types and column helpers for the
// extended Hamming(128,120) SECDED decoder.
package hamming_pkg;

  localparam int K  = 120;
  localparam int M  = 7;
  localparam int N  = K + M + 1;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    CLEAN,
    CORR,
    UNCORR
  } status_e;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_e;

  // k-th value in 3..127 that is not a power of two
  function automatic logic [M-1:0] col_of_data(
    input logic [CW-1:0] k
  );
    logic [M-1:0] v;
    v = M'(k) + M'(3);
    for (int j = 2; j < M; j++)
      if (v >= (M'(1) << j)) v = v + M'(1);
    return v;
  endfunction

  // payload index of a non-power-of-two column:
  // s minus the floor(log2 s)+1 powers of two below it, minus 1
  function automatic logic [M-1:0] data_idx_of_syn(
    input logic [M-1:0] s
  );
    logic [M-1:0] lg;
    lg = '0;
    for (int j = 0; j < M; j++)
      if (s[j]) lg = M'(j);
    return s - M'(2) - lg;
  endfunction

  function automatic logic is_pow2(input logic [M-1:0] s);
    return (s != '0) && ((s & (s - M'(1))) == '0);
  endfunction

endpackage

// File: rtl/hamming_syndrome_acc.sv
// Per-codeword bit counter, syndrome and overall parity
// accumulator; strobes done with the final syndrome/parity.
module hamming_syndrome_acc
  import hamming_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          bit_i,
  input  logic          valid_i,
  output logic [CW-1:0] idx_o,
  output logic          done_o,
  output logic [M-1:0]  syn_o,
  output logic          par_o
);

  logic [CW-1:0] cnt_q;
  logic [M-1:0]  syn_q, syn_d, col;
  logic          par_q, par_d;

  // column of the bit at the current serial position
  always_comb begin
    col = '0;
    if (cnt_q < CW'(K))
      col = col_of_data(cnt_q);
    else if (cnt_q != CW'(N-1))
      col = M'(1) << (cnt_q - CW'(K));
  end

  // running values including the bit on the input now
  always_comb begin
    syn_d = syn_q ^ (bit_i ? col : '0);
    par_d = par_q ^ bit_i;
  end

  assign idx_o  = cnt_q;
  assign done_o = valid_i && (cnt_q == CW'(N-1));
  assign syn_o  = syn_d;
  assign par_o  = par_d;

  // advance on accepted bits, clear at end of codeword
  always_ff @(posedge clk_i) begin
    if (rst_i || done_o) begin
      cnt_q <= '0;
      syn_q <= '0;
      par_q <= 1'b0;
    end else if (valid_i) begin
      cnt_q <= cnt_q + CW'(1);
      syn_q <= syn_d;
      par_q <= par_d;
    end
  end

endmodule

// File: rtl/hamming_dec.sv
// Serial SECDED decoder: ping-pong payload buffer,
// correction on drain, frame flags and saturating stats.
module hamming_dec
  import hamming_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             data_in_valid,
  output logic             data_out,
  output logic             valid,
  output logic             frame_corrected,
  output logic             frame_uncorrectable,
  output logic [CNT_W-1:0] corrected_count,
  output logic [CNT_W-1:0] uncorrectable_count
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CW-1:0] idx;
  logic          done, par;
  logic [M-1:0]  syn;

  hamming_syndrome_acc u_acc (
    .clk_i   (clk),
    .rst_i   (rst),
    .bit_i   (data_in),
    .valid_i (data_in_valid),
    .idx_o   (idx),
    .done_o  (done),
    .syn_o   (syn),
    .par_o   (par)
  );

  logic [K-1:0]  buf_q [2];
  state_e        state_q, state_d;
  logic [CW-1:0] rd_q, rd_d;
  logic          fill_q, fill_d, drain_q, drain_d;
  status_e       st_q, st_d, st_n;
  logic          flip_q, flip_d, flip_n;
  logic [M-1:0]  fidx_q, fidx_d, fidx_n;
  logic          valid_q, valid_d, data_q, data_d;
  logic          fc_q, fc_d, fu_q, fu_d;
  logic [CNT_W-1:0] corr_q, corr_d, unc_q, unc_d;

  // classify the finished codeword
  always_comb begin
    st_n   = CLEAN;
    flip_n = 1'b0;
    fidx_n = data_idx_of_syn(syn);
    if (syn == '0) begin
      st_n = par ? CORR : CLEAN;
    end else if (par) begin
      st_n   = CORR;
      flip_n = !is_pow2(syn);
    end else begin
      st_n = UNCORR;
    end
  end

  // swap halves on done and drain one bit per cycle
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    fill_d  = fill_q;
    drain_d = drain_q;
    st_d    = st_q;
    flip_d  = flip_q;
    fidx_d  = fidx_q;
    valid_d = 1'b0;
    data_d  = 1'b0;
    fc_d    = 1'b0;
    fu_d    = 1'b0;
    if (done) begin
      state_d = DRAIN;
      rd_d    = '0;
      fill_d  = !fill_q;
      drain_d = fill_q;
      st_d    = st_n;
      flip_d  = flip_n;
      fidx_d  = fidx_n;
      valid_d = 1'b1;
      data_d  = buf_q[fill_q][0]
              ^ (flip_n && fidx_n == '0);
    end else if (state_q == DRAIN) begin
      if (rd_q == CW'(K-1)) begin
        state_d = IDLE;
      end else begin
        rd_d    = rd_q + CW'(1);
        valid_d = 1'b1;
        data_d  = buf_q[drain_q][rd_d]
                ^ (flip_q && M'(rd_d) == fidx_q);
        fc_d    = (rd_d == CW'(K-1)) && st_q == CORR;
        fu_d    = (rd_d == CW'(K-1)) && st_q == UNCORR;
      end
    end
  end

  // saturating frame statistics
  always_comb begin
    corr_d = corr_q;
    unc_d  = unc_q;
    if (fc_d && corr_q != CMAX) corr_d = corr_q + CNT_W'(1);
    if (fu_d && unc_q != CMAX)  unc_d  = unc_q + CNT_W'(1);
  end

  // payload capture into the fill half
  always_ff @(posedge clk) begin
    if (data_in_valid && idx < CW'(K))
      buf_q[fill_q][idx] <= data_in;
  end

  // control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= '0;
      fill_q  <= 1'b0;
      drain_q <= 1'b1;
      st_q    <= CLEAN;
      flip_q  <= 1'b0;
      fidx_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= 1'b0;
      fc_q    <= 1'b0;
      fu_q    <= 1'b0;
      corr_q  <= '0;
      unc_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      fill_q  <= fill_d;
      drain_q <= drain_d;
      st_q    <= st_d;
      flip_q  <= flip_d;
      fidx_q  <= fidx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      fc_q    <= fc_d;
      fu_q    <= fu_d;
      corr_q  <= corr_d;
      unc_q   <= unc_d;
    end
  end

  assign valid               = valid_q;
  assign data_out            = data_q;
  assign frame_corrected     = fc_q;
  assign frame_uncorrectable = fu_q;
  assign corrected_count     = corr_q;
  assign uncorrectable_count = unc_q;

endmodule

// File: tb/tb_hamming_dec.sv
// Directed bench for hamming_dec: clean, corrected,
// uncorrectable, streaming, gapped and reset frames.
module tb_hamming_dec;

  logic        clk = 1'b0;
  logic        rst, data_in, data_in_valid;
  logic        data_out, valid;
  logic        frame_corrected, frame_uncorrectable;
  logic [31:0] corrected_count, uncorrectable_count;

  hamming_dec #(.CNT_W(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .data_in             (data_in),
    .data_in_valid       (data_in_valid),
    .data_out            (data_out),
    .valid               (valid),
    .frame_corrected     (frame_corrected),
    .frame_uncorrectable (frame_uncorrectable),
    .corrected_count     (corrected_count),
    .uncorrectable_count (uncorrectable_count)
  );

  always #5 clk = ~clk;

  int   n_vec = 0, n_err = 0;
  int   colt[120];
  logic got_q[$];
  int   run = 0, bursts = 0, burst_bad = 0;
  int   fc_n = 0, fu_n = 0, flag_bad = 0;
  int   ecorr = 0, eunc = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  // output monitor: collects bits, burst lengths, flags
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      got_q.push_back(data_out);
      run++;
    end else if (run != 0) begin
      bursts++;
      if (run != 120) burst_bad++;
      run = 0;
    end
    if (frame_corrected === 1'b1) begin
      fc_n++;
      if (!(valid === 1'b1 && run == 120)) flag_bad++;
    end
    if (frame_uncorrectable === 1'b1) begin
      fu_n++;
      if (!(valid === 1'b1 && run == 120)) flag_bad++;
    end
  end

  function automatic logic [127:0] enc(input logic [119:0] pl);
    logic [6:0]   s;
    logic [127:0] cw;
    s = '0;
    for (int k = 0; k < 120; k++)
      if (pl[k]) s ^= 7'(colt[k]);
    cw = '0;
    cw[119:0]   = pl;
    cw[126:120] = s;
    cw[127]     = ^cw[126:0];
    return cw;
  endfunction

  function automatic logic [119:0] prbs(input logic [6:0] seed);
    logic [6:0]   s;
    logic [119:0] r;
    s = seed;
    for (int i = 0; i < 120; i++) begin
      r[i] = s[6];
      s = {s[5:0], s[6] ^ s[5]};
    end
    return r;
  endfunction

  task automatic send(input logic [127:0] cw,
                      input int nbits, input bit gaps);
    for (int i = 0; i < nbits; i++) begin
      if (gaps) begin
        @(negedge clk);
        data_in_valid = 1'b0;
        data_in = ~cw[i];
      end
      @(negedge clk);
      data_in = cw[i];
      data_in_valid = 1'b1;
    end
  endtask

  task automatic check_bits(input string tag,
                            input logic [119:0] exp);
    int mism;
    mism = 0;
    check({tag, ".len"}, got_q.size(), 120);
    for (int i = 0; i < 120 && i < got_q.size(); i++)
      if (got_q[i] !== exp[i]) mism++;
    check({tag, ".bits"}, mism, 0);
  endtask

  task automatic frame(input string tag,
                       input logic [119:0] pl,
                       input logic [127:0] flips,
                       input logic [119:0] exp);
    got_q.delete();
    send(enc(pl) ^ flips, 128, 1'b0);
    @(negedge clk);
    data_in_valid = 1'b0;
    data_in = 1'b0;
    check({tag, ".lat"}, valid, 1);
    repeat (124) @(negedge clk);
    check_bits(tag, exp);
    check({tag, ".ccnt"}, corrected_count, ecorr);
    check({tag, ".ucnt"}, uncorrectable_count, eunc);
    check({tag, ".fc"}, fc_n, ecorr);
    check({tag, ".fu"}, fu_n, eunc);
  endtask

  task automatic stream(input string tag, input bit gaps);
    logic [119:0] pls[10];
    int mism;
    got_q.delete();
    bursts = 0;
    burst_bad = 0;
    for (int f = 0; f < 10; f++) begin
      pls[f] = prbs(7'(f * 11 + (gaps ? 5 : 3)));
      send(enc(pls[f]), 128, gaps);
    end
    @(negedge clk);
    data_in_valid = 1'b0;
    repeat (125) @(negedge clk);
    check({tag, ".len"}, got_q.size(), 1200);
    mism = 0;
    for (int i = 0; i < 1200 && i < got_q.size(); i++)
      if (got_q[i] !== pls[i / 120][i % 120]) mism++;
    check({tag, ".bits"}, mism, 0);
    check({tag, ".bursts"}, bursts, 10);
    check({tag, ".burstlen"}, burst_bad, 0);
  endtask

  initial begin
    logic [119:0] pl, ex;
    logic [127:0] fl;
    int n;
    n = 0;
    for (int v = 3; v < 128; v++)
      if ((v & (v - 1)) != 0) begin
        colt[n] = v;
        n++;
      end

    rst = 1'b1;
    data_in = 1'b0;
    data_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.valid", valid, 0);
    check("rst.data", data_out, 0);
    check("rst.fc", frame_corrected, 0);
    check("rst.fu", frame_uncorrectable, 0);
    check("rst.ccnt", corrected_count, 0);
    check("rst.ucnt", uncorrectable_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // clean frames
    pl = '0;
    frame("clean0", pl, '0, pl);
    check("clean0.flagpos", flag_bad, 0);
    pl = prbs(7'h5a);
    frame("cleanprbs", pl, '0, pl);

    // single data errors
    pl = prbs(7'h21);
    fl = '0;
    fl[0] = 1'b1;
    ecorr++;
    frame("d0", pl, fl, pl);
    check("d0.flagpos", flag_bad, 0);
    fl = '0;
    fl[119] = 1'b1;
    ecorr++;
    frame("d119", pl, fl, pl);

    // parity-only errors
    pl = prbs(7'h33);
    fl = '0;
    fl[123] = 1'b1;
    ecorr++;
    frame("p3", pl, fl, pl);
    fl = '0;
    fl[127] = 1'b1;
    ecorr++;
    frame("q", pl, fl, pl);

    // double error passes raw payload
    pl = prbs(7'h4c);
    fl = '0;
    fl[5] = 1'b1;
    fl[40] = 1'b1;
    ex = pl;
    ex[5] = ~ex[5];
    ex[40] = ~ex[40];
    eunc++;
    frame("dbl", pl, fl, ex);
    check("dbl.flagpos", flag_bad, 0);

    stream("b2b", 1'b0);
    stream("gap", 1'b1);

    // reset while the previous frame drains
    send(enc(prbs(7'h11)), 128, 1'b0);
    send(enc(prbs(7'h12)), 60, 1'b0);
    @(negedge clk);
    check("mrst.pre", valid, 1);
    rst = 1'b1;
    data_in_valid = 1'b0;
    @(negedge clk);
    check("mrst.valid", valid, 0);
    check("mrst.ccnt", corrected_count, 0);
    check("mrst.ucnt", uncorrectable_count, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    ecorr = 0;
    eunc = 0;
    fc_n = 0;
    fu_n = 0;
    pl = prbs(7'h6e);
    frame("mrst.new", pl, '0, pl);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
